// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial unsigned adder sequencing one shared full-adder cell
// over WIDTH cycles with a start/busy/done handshake.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q, sum_sh_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, p, g0, s, g1, c, last;
    // Full-adder cell built from two half adders; carry is the OR of both generates.
    half_adder u_ha0 (.a_i(a_sh_q[0]), .b_i(b_sh_q[0]), .s_o(p), .c_o(g0));
    half_adder u_ha1 (.a_i(p), .b_i(carry_q), .s_o(s), .c_o(g1));
    assign c        = g0 | g1;
    assign sum_sh_d = {s, sum_sh_q[WIDTH-1:1]};
    assign last     = cnt_q == CW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= RUN;
                    a_sh_q   <= a;
                    b_sh_q   <= b;
                    sum_sh_q <= '0;
                    cnt_q    <= '0;
                    carry_q  <= 1'b0;
                    busy     <= 1'b1;
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= c;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last) begin
                        state_q <= DONE;
                        sum     <= sum_sh_d;
                        cout    <= c;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: checks WIDTH=4 and WIDTH=8 instances against a cycle-level
// timeline model of the handshake plus hand-computed sums.
module tb_serial_adder_ctrl;
    logic clk = 0, rst_n = 1;
    logic s4 = 0, busy4, done4, cout4;
    logic [3:0] a4 = 0, b4 = 0, sum4;
    logic s8 = 0, busy8, done8, cout8;
    logic [7:0] a8 = 0, b8 = 0, sum8;
    int pass = 0, total = 0, lat;

    serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: phase 0 idle, 1..W busy, W+1 done pulse; result appears with the done pulse.
    int ph4 = 0, ph8 = 0;
    logic [4:0] pend4, res4 = 0;
    logic [8:0] pend8, res8 = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph4 = 0; ph8 = 0; res4 = 0; res8 = 0;
        end else begin
            if (ph4 == 0) begin
                if (s4) begin ph4 = 1; pend4 = {1'b0, a4} + {1'b0, b4}; end
            end else if (ph4 == 4) begin ph4 = 5; res4 = pend4; end
            else if (ph4 == 5) ph4 = 0;
            else ph4++;
            if (ph8 == 0) begin
                if (s8) begin ph8 = 1; pend8 = {1'b0, a8} + {1'b0, b8}; end
            end else if (ph8 == 8) begin ph8 = 9; res8 = pend8; end
            else if (ph8 == 9) ph8 = 0;
            else ph8++;
        end
    end

    always @(negedge clk) begin
        chk("m_busy4", busy4, (ph4 >= 1 && ph4 <= 4) ? 1 : 0);
        chk("m_done4", done4, ph4 == 5 ? 1 : 0);
        chk("m_sum4", {cout4, sum4}, res4);
        chk("m_busy8", busy8, (ph8 >= 1 && ph8 <= 8) ? 1 : 0);
        chk("m_done8", done8, ph8 == 9 ? 1 : 0);
        chk("m_sum8", {cout8, sum8}, res8);
    end

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input int es, input int ec);
        a4 = a; b4 = b; s4 = 1; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); s4 = 0;
            if (done4) begin lat = i; break; end
        end
        chk("lat4", lat, 5); chk("sum4", sum4, es); chk("cout4", cout4, ec);
        @(negedge clk);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] e;
        e = {1'b0, a} + {1'b0, b};
        a8 = a; b8 = b; s8 = 1; lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk); s8 = 0;
            if (done8) begin lat = i; break; end
        end
        chk("lat8", lat, 9); chk("sum8", {cout8, sum8}, e);
        @(negedge clk);
    endtask

    initial begin
        int al[6] = '{0, 1, 127, 128, 254, 255};
        #1 rst_n = 0;
        @(negedge clk); rst_n = 1;
        chk("rst_sum4", sum4, 0); chk("rst_busy4", busy4, 0);
        @(negedge clk);
        op4(5, 3, 8, 0);
        #2 rst_n = 0;
        #1 chk("async_sum4", sum4, 0); chk("async_busy4", busy4, 0);
        chk("async_done4", done4, 0); chk("async_cout4", cout4, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        op4(15, 1, 0, 1);
        op4(15, 15, 14, 1);
        op4(0, 0, 0, 0);
        a4 = 9; b4 = 9; s4 = 1; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); a4 = 1;
            if (done4) begin lat = i; break; end
        end
        chk("hold_lat4", lat, 5); chk("hold_sum4", sum4, 2); chk("hold_cout4", cout4, 1);
        @(negedge clk); chk("hold_idle4", busy4, 0);
        @(negedge clk); chk("hold_rerun4", busy4, 1); s4 = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done4) begin lat = i; break; end
        end
        chk("rerun_lat4", lat, 4); chk("rerun_sum4", sum4, 10); chk("rerun_cout4", cout4, 0);
        @(negedge clk);
        a4 = 7; b4 = 7; s4 = 1;
        @(negedge clk); s4 = 0;
        @(negedge clk);
        #1 rst_n = 0;
        #1 chk("mid_busy4", busy4, 0); chk("mid_sum4", sum4, 0);
        @(negedge clk); rst_n = 1;
        repeat (6) @(negedge clk);
        chk("mid_after_sum4", sum4, 0);
        op4(2, 3, 5, 0);
        foreach (al[i]) for (int b = 0; b < 256; b++) op8(8'(al[i]), 8'(b));
        for (int k = 0; k < 150; k++) op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
